// File: rtl/noc_inject_arbiter.sv
// Round-robin NoC injection arbiter with a one-entry hold per port; capture-to-write latency is one cycle.
// Issues only when the NoC can take a packet (full, or almost_full after a write); optional NOC_ARB_STALL_CNT_EN stall counter.
module noc_inject_arbiter #(
  parameter int WIDTH   = 12,
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     full,
  input  logic                     almost_full,
  output logic [WIDTH-1:0]         dataOut,
  output logic                     write,
  output logic [PTR_W-1:0]         grant_id,
  output logic                     busy
`ifdef NOC_ARB_STALL_CNT_EN
  ,
  input  logic                     stall_clr,
  output logic [15:0]              stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] hold_vld;
  logic [WIDTH-1:1]   hold_data [NUM_REQ];
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   k;
  logic [PTR_W-1:0]   idx;
  logic               any_vld;
  logic               can_send;
  logic               grant;
  logic [NUM_REQ-1:0] unused_vbit;

  assign req_ready = ~hold_vld;
  assign busy      = any_vld;

  always_comb begin
    any_vld  = |hold_vld;
    can_send = write ? ~almost_full : ~full;
    grant    = can_send & any_vld;
    k        = rr_ptr;
    idx      = '0;
    // Scan from the far end so the entry closest to rr_ptr wins.
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = PTR_W'((int'(rr_ptr) + off) % NUM_REQ);
      if (hold_vld[idx]) k = idx;
    end
  end

  // The incoming valid bit is never stored; the issued packet forces bit 0 high.
  always_comb begin
    unused_vbit = '0;
    for (int i = 0; i < NUM_REQ; i++) unused_vbit[i] = req_data[i*WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_vld <= '0;
      rr_ptr   <= '0;
      write    <= 1'b0;
      dataOut  <= '0;
      grant_id <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant && k == PTR_W'(i))
          hold_vld[i] <= 1'b0;
        else if (req_valid[i] && !hold_vld[i])
          hold_vld[i] <= 1'b1;
      end
      write <= grant;
      if (grant) begin
        dataOut  <= {hold_data[k], 1'b1};
        grant_id <= k;
        rr_ptr   <= (k == PTR_W'(NUM_REQ - 1)) ? '0 : k + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++)
      if (req_valid[i] && !hold_vld[i])
        hold_data[i] <= req_data[i*WIDTH+1 +: WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant)                     state_nxt = ISSUE;
        else if (any_vld && !can_send) state_nxt = WAIT;
      end
      ISSUE: begin
        if (grant)                     state_nxt = ISSUE;
        else if (any_vld && !can_send) state_nxt = WAIT;
        else                           state_nxt = IDLE;
      end
      WAIT: begin
        if (grant)         state_nxt = ISSUE;
        else if (!any_vld) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef NOC_ARB_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || stall_clr)
      stall_cnt <= '0;
    else if (state == WAIT && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Bench for noc_inject_arbiter: directed scenarios plus randomized traffic against a queue-free array model.
module tb_noc_inject_arbiter;
  localparam int W = 12;
  localparam int N = 4;
  localparam int P = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           full, almost_full;
  logic [W-1:0]   dataOut;
  logic           write;
  logic [P-1:0]   grant_id;
  logic           busy;
`ifdef NOC_ARB_STALL_CNT_EN
  logic           stall_clr;
  logic [15:0]    stall_cnt;
`endif

  always #5 clk = ~clk;

  noc_inject_arbiter #(.WIDTH(W), .NUM_REQ(N), .PTR_W(P)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .full(full), .almost_full(almost_full),
    .dataOut(dataOut), .write(write), .grant_id(grant_id), .busy(busy)
`ifdef NOC_ARB_STALL_CNT_EN
    , .stall_clr(stall_clr), .stall_cnt(stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: what the NoC side should show after the last edge.
  logic [N-1:0] m_pend;
  logic [W-1:0] m_pdata [N];
  int           m_ptr;
  logic         m_wr;
  logic [W-1:0] m_out;
  int           m_gid;
  int           n_acc, n_drop, n_wr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*W-1:0] slot(input int i, input logic [W-1:0] p);
    logic [N*W-1:0] r;
    r = '0;
    r[i*W +: W] = p;
    return r;
  endfunction

  task automatic check_outputs();
    logic [N-1:0] er;
    logic         eb;
    er = ~m_pend;
    eb = |m_pend;
    check("write",     32'(write),      32'(m_wr));
    check("dataOut",   32'(dataOut),    32'(m_out));
    check("grant_id",  32'(grant_id),   32'(m_gid));
    check("req_ready", 32'(req_ready),  32'(er));
    check("busy",      32'(busy),       32'(eb));
    check("rr_ptr",    32'(dut.rr_ptr), 32'(m_ptr));
    if (write === 1'b1) n_wr++;
  endtask

  task automatic model_step(input logic [N-1:0] v, input logic [N*W-1:0] d,
                            input logic f, input logic af, input logic rst);
    logic [N-1:0] old;
    logic         can;
    int           k;
    old = m_pend;
    k   = -1;
    if (rst) begin
      for (int i = 0; i < N; i++) if (m_pend[i]) n_drop++;
      m_pend = '0; m_ptr = 0; m_wr = 1'b0; m_out = '0; m_gid = 0;
      return;
    end
    can = m_wr ? !af : !f;
    if (can)
      for (int off = 0; off < N; off++)
        if (k < 0 && old[(m_ptr + off) % N]) k = (m_ptr + off) % N;
    for (int i = 0; i < N; i++)
      if (v[i] && !old[i]) begin
        m_pend[i]  = 1'b1;
        m_pdata[i] = d[i*W +: W];
        n_acc++;
      end
    if (k >= 0) begin
      m_out     = {m_pdata[k][W-1:1], 1'b1};
      m_gid     = k;
      m_wr      = 1'b1;
      m_pend[k] = 1'b0;
      m_ptr     = (k + 1) % N;
    end else begin
      m_wr = 1'b0;
    end
  endtask

  // One clock: check outputs of the previous edge, drive inputs, advance model, clock.
  task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d,
                       input logic f, input logic af, input logic rst);
    check_outputs();
    req_valid = v; req_data = d; full = f; almost_full = af; reset = rst;
    model_step(v, d, f, af, rst);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic f, input logic af);
    cycle('0, '0, f, af, 1'b0);
  endtask

  initial begin
    logic [N-1:0]   v;
    logic [N*W-1:0] d;
    logic [N-1:0]   rdy;
    logic           f, af, rst;

    reset = 1'b1; req_valid = '0; req_data = '0; full = 1'b0; almost_full = 1'b0;
`ifdef NOC_ARB_STALL_CNT_EN
    stall_clr = 1'b0;
`endif
    m_pend = '0; m_ptr = 0; m_wr = 1'b0; m_out = '0; m_gid = 0;
    n_acc = 0; n_drop = 0; n_wr = 0;
    @(posedge clk);
    @(negedge clk);

    // Single packet on port 2.
    cycle('0, '0, 1'b0, 1'b0, 1'b1);
    check("rst_write", 32'(write), 32'h0);
    check("rst_ready", 32'(req_ready), 32'hF);
    check("rst_busy",  32'(busy), 32'h0);
    cycle(4'b0100, slot(2, 12'h5A4), 1'b0, 1'b0, 1'b0);
    check("t1_ready_lo", 32'(req_ready[2]), 32'h0);
    idle(1'b0, 1'b0);
    check("t1_write", 32'(write), 32'h1);
    check("t1_data",  32'(dataOut), 32'h5A5);
    check("t1_gid",   32'(grant_id), 32'h2);
    check("t1_ready", 32'(req_ready[2]), 32'h1);

    // All four ports at once.
    cycle('0, '0, 1'b0, 1'b0, 1'b1);
    cycle(4'hF, {12'h444, 12'h332, 12'h220, 12'h11E}, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      idle(1'b0, 1'b0);
      check("t2_write", 32'(write), 32'h1);
      check("t2_gid",   32'(grant_id), 32'(i));
    end
    check("t2_ptr", 32'(dut.rr_ptr), 32'h0);

    // almost_full after the first write, then NoC stays full.
    cycle('0, '0, 1'b0, 1'b0, 1'b1);
    cycle(4'hF, {12'h8F0, 12'h7E0, 12'h6D0, 12'h5C0}, 1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1);
    check("t3_first", 32'(write), 32'h1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1, 1'b1);
      check("t3_stall", 32'(write), 32'h0);
    end
    for (int i = 1; i < N; i++) begin
      idle(1'b0, 1'b0);
      check("t3_gid", 32'(grant_id), 32'(i));
    end

    // Port 1 held through ten full cycles.
    cycle('0, '0, 1'b0, 1'b0, 1'b1);
    cycle(4'b0010, slot(1, 12'h3C6), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      idle(1'b1, 1'b0);
      check("t4_write", 32'(write), 32'h0);
      check("t4_ready", 32'(req_ready[1]), 32'h0);
      check("t4_busy",  32'(busy), 32'h1);
    end
    idle(1'b0, 1'b0);
    check("t4_data", 32'(dataOut), 32'h3C7);
    check("t4_gid",  32'(grant_id), 32'h1);
`ifdef NOC_ARB_STALL_CNT_EN
    check("t4_stall_cnt", 32'(stall_cnt), 32'd10);
`endif

    // Reset while three packets are still pending.
    cycle('0, '0, 1'b0, 1'b0, 1'b1);
    cycle(4'hF, {12'h0AA, 12'h0BB, 12'h0CC, 12'h0DD}, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    check("t5_pre_write", 32'(write), 32'h1);
    cycle('0, '0, 1'b0, 1'b0, 1'b1);
    check("t5_write", 32'(write), 32'h0);
    check("t5_busy",  32'(busy), 32'h0);
    check("t5_ready", 32'(req_ready), 32'hF);
    check("t5_ptr",   32'(dut.rr_ptr), 32'h0);
    for (int i = 0; i < 4; i++) begin
      idle(1'b0, 1'b0);
      check("t5_no_issue", 32'(write), 32'h0);
    end

    // Pointer at 3 with ports 0 and 3 pending.
    cycle(4'b0100, slot(2, 12'h222), 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    check("t6_ptr3", 32'(dut.rr_ptr), 32'h3);
    cycle(4'b1001, slot(3, 12'hD30) | slot(0, 12'hD00), 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    check("t6_gid_a", 32'(grant_id), 32'h3);
    idle(1'b0, 1'b0);
    check("t6_gid_b", 32'(grant_id), 32'h0);
    check("t6_ptr",   32'(dut.rr_ptr), 32'h1);

    // Random traffic; a refused requester keeps offering the same packet.
    v = '0; d = '0;
    for (int c = 0; c < 800; c++) begin
      rdy = ~m_pend;
      for (int i = 0; i < N; i++)
        if (!v[i] || rdy[i]) begin
          v[i]          = ($urandom_range(0, 2) != 0);
          d[i*W +: W]   = W'($urandom);
        end
      f   = ($urandom_range(0, 3) == 0);
      af  = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 149) == 0);
      cycle(v, d, f, af, rst);
      if (rst) v = '0;
    end

    for (int i = 0; i < 10; i++) idle(1'b0, 1'b0);
    check_outputs();
    check("no_loss", 32'(n_wr + n_drop), 32'(n_acc));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
